// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle radix-2 shift-add multiply and
// restoring divide on magnitudes, with a sign-fix cycle that writes HI/LO.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        res_neg_q, res_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // Signed ops (op[0]==0) work on magnitudes; signs are re-applied in FIX.
  assign a_neg = ~op[0] & a[31];
  assign b_neg = ~op[0] & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  // Multiply: work = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, work_q[63:32]} + {1'b0, (work_q[0] ? opnd_q : 32'd0)};
  // Divide: work = {remainder, dividend/quotient}; trial subtract on the shifted remainder.
  assign div_diff = work_q[63:31] - {1'b0, opnd_q};

  assign prod_fix = res_neg_q ? (~work_q + 64'd1) : work_q;
  assign quot_fix = res_neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix  = rem_neg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    work_d     = work_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d    = S_CALC;
          cnt_d      = 6'd0;
          is_div_d   = op[1];
          res_neg_d  = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          div_zero_d = (b == 32'd0);
          opnd_d     = b_mag;
          work_d     = {32'd0, a_mag};
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (div_diff[32]) work_d = {work_q[62:0], 1'b0};
          else              work_d = {div_diff[31:0], work_q[30:0], 1'b1};
        end else begin
          work_d = {mul_sum, work_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // Zero divisor: quotient forced to all ones; remainder already equals a.
          hi_d = rem_fix;
          lo_d = div_zero_q ? 32'hFFFF_FFFF : quot_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= 32'd0;
      work_q     <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      work_q     <= work_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: arithmetic reference model,
// latency/pulse checks, MTHI/MTLO interaction and mid-operation reset.
module tb_muldiv_unit;

  // Handshake: start is sampled only while busy==0; each accepted start yields
  // exactly one done pulse 34 edges later, with HI/LO valid and busy==0 in that cycle.

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          iss_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, up;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = 64'd0;
    case (o)
      2'b00: r = sx * sy;
      2'b01: begin up = ux * uy; r = up; end
      2'b10: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else            r = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        logic [63:0] e;
        int          t0;
        e  = exp_q.pop_front();
        t0 = iss_q.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
        chk("done_latency", 64'(cyc - t0), 64'd34);
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        model_hi = e[63:32];
        model_lo = e[31:0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk({name, "_timeout"}, 64'd1, 64'd0);
      exp_q.delete();
      iss_q.delete();
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit repulse, input bit mt_same);
    logic [31:0] held_hi, held_lo, mtv;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    mtv = $urandom;
    held_hi = model_hi;
    held_lo = model_lo;
    if (mt_same) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = mtv;
      held_hi = mtv; held_lo = mtv;
    end
    exp_q.push_back(ref_model(o, x, y));
    iss_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
    #1;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("hold_hi_early", {32'd0, hi}, {32'd0, held_hi});
    repeat (4) @(negedge clk);
    // Writes and restarts while busy must have no effect.
    lo_we = 1'b1; hi_we = 1'b1; wdata = ~held_lo;
    if (repulse) begin
      start = 1'b1; op = $urandom_range(0, 3);
    end
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    #1;
    chk("hold_lo_busy", {32'd0, lo}, {32'd0, held_lo});
    chk("hold_hi_busy", {32'd0, hi}, {32'd0, held_hi});
    wait_done("op");
  endtask

  task automatic do_mt(input bit wh, input bit wl, input logic [31:0] v);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wdata = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) model_hi = v;
    if (wl) model_lo = v;
    #1;
    chk("mt_hi", {32'd0, hi}, {32'd0, model_hi});
    chk("mt_lo", {32'd0, lo}, {32'd0, model_lo});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    do_mt(1'b1, 1'b0, 32'h1234_5678);
    do_mt(1'b0, 1'b1, 32'hCAFE_F00D);
    do_op(2'b00, 32'd6, 32'hFFFF_FFF9, 1'b1, 1'b1);

    // Randomized operations with idle gaps and occasional MTHI/MTLO
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    iss_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    chk("async_rst_hi", {32'd0, hi}, 64'd0);
    chk("async_rst_lo", {32'd0, lo}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("post_rst_idle_busy", {63'd0, busy}, 64'd0);
    do_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("post_rst_model_lo", {32'd0, model_lo}, 64'd12);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
